// File: rtl/pifo_traffic_gen_if.sv
// PIFO-side request/response bundle: push/pop strobes toward the queue,
// pop responses back from it.
interface pifo_traffic_gen_if #(
  parameter int BITPORT = 1,
  parameter int BITPRIO = 8,
  parameter int BITDATA = 7
);
  logic               pop_0;
  logic [BITPORT-1:0] oprt_0;
  logic               push_1;
  logic [BITPORT-1:0] uprt_1;
  logic [BITPRIO-1:0] upri_1;
  logic [BITDATA-1:0] udin_1;
  logic               ovld_0;
  logic [BITDATA-1:0] odout_0;

  modport master (
    output pop_0, oprt_0, push_1, uprt_1, upri_1, udin_1,
    input  ovld_0, odout_0
  );

  modport slave (
    input  pop_0, oprt_0, push_1, uprt_1, upri_1, udin_1,
    output ovld_0, odout_0
  );
endinterface

// File: rtl/pifo_traffic_gen.sv
// LFSR-driven push/pop traffic source for the PIFO benchmark. It tracks occupancy
// and a free-ID bitmap, and flags pop responses that carry unallocated IDs.
module pifo_traffic_gen #(
  parameter int          NUMPIFO = 128,
  parameter int          BITPORT = 1,
  parameter int          BITPRIO = 8,
  parameter int          BITDATA = $clog2(NUMPIFO),
  parameter logic [31:0] SEED    = 32'hACE1_2024
) (
  input  logic               user_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [BITPORT-1:0] port_sel,
  pifo_traffic_gen_if.master pifo,
  output logic [BITDATA:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic [31:0]        push_cnt,
  output logic [31:0]        pop_cnt,
  output logic               err
);

  localparam logic [31:0]      SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0]      POLY     = 32'h8020_0003;
  localparam logic [BITDATA:0] CAP      = (BITDATA+1)'(NUMPIFO);

  logic [31:0]        r_lfsr;
  logic [NUMPIFO-1:0] r_bitmap;
  logic [BITDATA:0]   r_occ;
  logic               r_full;
  logic               r_empty;
  logic [31:0]        r_push_cnt;
  logic [31:0]        r_pop_cnt;
  logic               r_err;
  logic               r_push;
  logic               r_pop;
  logic [BITPORT-1:0] r_oprt;
  logic [BITPORT-1:0] r_uprt;
  logic [BITPRIO-1:0] r_upri;
  logic [BITDATA-1:0] r_udin;

  logic [31:0]        w_lfsr_next;
  logic               w_want_push;
  logic               w_want_pop;
  logic               w_push_go;
  logic               w_pop_go;
  logic [BITDATA-1:0] w_free_id;
  logic               w_free_any;
  logic [NUMPIFO-1:0] w_bitmap_next;
  logic               w_bad_id;
  logic [BITDATA:0]   w_occ_next;

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'd0);

  always_comb begin
    w_want_push = 1'b0;
    w_want_pop  = 1'b0;
    case (mode)
      2'd1:    w_want_push = 1'b1;
      2'd2:    w_want_pop  = 1'b1;
      2'd3: begin
        w_want_push = r_lfsr[0];
        w_want_pop  = r_lfsr[1];
      end
      default: ;
    endcase
  end

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    w_free_id  = '0;
    w_free_any = 1'b0;
    for (int i = NUMPIFO - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) begin
        w_free_id  = BITDATA'(i);
        w_free_any = 1'b1;
      end
    end
  end

  assign w_push_go = en && w_want_push && (r_occ < CAP) && w_free_any;
  assign w_pop_go  = en && w_want_pop && (r_occ != '0);

  // Free from the response first, then allocate; allocation was chosen from the
  // pre-edge bitmap so it can never collide with a legitimate free.
  always_comb begin
    w_bitmap_next = r_bitmap;
    w_bad_id      = 1'b0;
    if (pifo.ovld_0) begin
      if (r_bitmap[pifo.odout_0]) w_bitmap_next[pifo.odout_0] = 1'b0;
      else                        w_bad_id = 1'b1;
    end
    if (w_push_go) w_bitmap_next[w_free_id] = 1'b1;
  end

  assign w_occ_next = r_occ + {{BITDATA{1'b0}}, w_push_go} - {{BITDATA{1'b0}}, w_pop_go};

  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_lfsr     <= SEED_EFF;
      r_bitmap   <= '0;
      r_occ      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_err      <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_oprt     <= '0;
      r_uprt     <= '0;
      r_upri     <= '0;
      r_udin     <= '0;
    end else begin
      r_push   <= w_push_go;
      r_pop    <= w_pop_go;
      r_oprt   <= port_sel;
      r_uprt   <= port_sel;
      r_bitmap <= w_bitmap_next;
      r_occ    <= w_occ_next;
      r_full   <= (w_occ_next == CAP);
      r_empty  <= (w_occ_next == '0);
      if (en)        r_lfsr     <= w_lfsr_next;
      if (w_push_go) begin
        r_udin     <= w_free_id;
        r_upri     <= r_lfsr[BITPRIO+1:2];
        r_push_cnt <= r_push_cnt + 32'd1;
      end
      if (w_pop_go)  r_pop_cnt  <= r_pop_cnt + 32'd1;
      if (w_bad_id)  r_err      <= 1'b1;
    end
  end

  assign pifo.pop_0  = r_pop;
  assign pifo.oprt_0 = r_oprt;
  assign pifo.push_1 = r_push;
  assign pifo.uprt_1 = r_uprt;
  assign pifo.upri_1 = r_upri;
  assign pifo.udin_1 = r_udin;
  assign occupancy   = r_occ;
  assign full        = r_full;
  assign empty       = r_empty;
  assign push_cnt    = r_push_cnt;
  assign pop_cnt     = r_pop_cnt;
  assign err         = r_err;

endmodule

// File: tb/tb_pifo_traffic_gen.sv
// Bench for pifo_traffic_gen: reference model predicts strobes and push payloads,
// a small PIFO model returns popped IDs.
module tb_pifo_traffic_gen;
  localparam int          NUMPIFO = 128;
  localparam int          BITPORT = 1;
  localparam int          BITPRIO = 8;
  localparam int          BITDATA = 7;
  localparam logic [31:0] SEED    = 32'hACE1_2024;
  localparam logic [31:0] POLY    = 32'h8020_0003;

  logic               user_clk = 1'b0;
  logic               rst      = 1'b1;
  logic               en       = 1'b0;
  logic [1:0]         mode     = 2'd0;
  logic [BITPORT-1:0] port_sel = '1;
  logic [BITDATA:0]   occupancy;
  logic               full, empty, err;
  logic [31:0]        push_cnt, pop_cnt;

  pifo_traffic_gen_if #(.BITPORT(BITPORT), .BITPRIO(BITPRIO), .BITDATA(BITDATA)) pif ();

  pifo_traffic_gen #(
    .NUMPIFO(NUMPIFO), .BITPORT(BITPORT), .BITPRIO(BITPRIO), .BITDATA(BITDATA), .SEED(SEED)
  ) dut (
    .user_clk (user_clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .port_sel (port_sel),
    .pifo     (pif.master),
    .occupancy(occupancy),
    .full     (full),
    .empty    (empty),
    .push_cnt (push_cnt),
    .pop_cnt  (pop_cnt),
    .err      (err)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {logic [BITDATA-1:0] id; logic [BITPRIO-1:0] prio;} ent_t;
  typedef struct {logic [BITDATA-1:0] id; int due;} resp_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model of the generator
  logic [31:0]        m_lfsr   = SEED;
  logic [NUMPIFO-1:0] m_bitmap = '0;
  int                 m_occ    = 0;
  bit                 m_err    = 1'b0;
  bit                 e_push, e_pop;
  ent_t               exp_q[$];
  ent_t               sb_exp;
  bit                 sb_valid;

  // PIFO environment
  ent_t  store_q[$];
  resp_t resp_q[$];
  bit    hold_resp = 1'b0;

  task automatic tick(input bit r, input bit e, input logic [1:0] m,
                      input bit f_vld, input logic [BITDATA-1:0] f_id);
    logic               vld;
    logic [BITDATA-1:0] oid, fid;
    bit                 wp, wq, found;
    resp_t              rr;
    ent_t               ent;
    int                 k;
    vld = 1'b0;
    oid = '0;
    if (f_vld) begin
      vld = 1'b1;
      oid = f_id;
    end else if (!hold_resp && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      rr  = resp_q.pop_front();
      vld = 1'b1;
      oid = rr.id;
    end
    rst = r; en = e; mode = m;
    pif.ovld_0 = vld; pif.odout_0 = oid;
    e_push = 1'b0;
    e_pop  = 1'b0;
    if (r) begin
      m_lfsr = SEED; m_bitmap = '0; m_occ = 0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      wp = (m == 2'd1) || (m == 2'd3 && m_lfsr[0]);
      wq = (m == 2'd2) || (m == 2'd3 && m_lfsr[1]);
      found = 1'b0;
      fid   = '0;
      for (int i = 0; i < NUMPIFO; i++)
        if (!found && !m_bitmap[i]) begin found = 1'b1; fid = BITDATA'(i); end
      e_push = e && wp && (m_occ < NUMPIFO) && found;
      e_pop  = e && wq && (m_occ > 0);
      if (e_push) exp_q.push_back('{fid, m_lfsr[BITPRIO+1:2]});
      if (vld) begin
        if (m_bitmap[oid]) m_bitmap[oid] = 1'b0;
        else               m_err = 1'b1;
      end
      if (e_push) m_bitmap[fid] = 1'b1;
      m_occ = m_occ + int'(e_push) - int'(e_pop);
      if (e) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'd0);
    end
    @(posedge user_clk);
    @(negedge user_clk);
    cyc++;
    sb_valid = 1'b0;
    if (r) begin
      store_q.delete();
      resp_q.delete();
    end else begin
      if (pif.pop_0 && store_q.size() > 0) begin
        k = 0;
        for (int i = 1; i < store_q.size(); i++)
          if (store_q[i].prio < store_q[k].prio) k = i;
        ent = store_q[k];
        store_q.delete(k);
        if (!hold_resp) resp_q.push_back('{ent.id, cyc + 3});
      end
      if (pif.push_1) begin
        store_q.push_back('{pif.udin_1, pif.upri_1});
        if (exp_q.size() > 0) begin
          sb_exp   = exp_q.pop_front();
          sb_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, '0);
    tick(1, 0, 0, 0, '0);
    checks++; if ({pif.push_1, pif.pop_0} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {pif.push_1, pif.pop_0}); end
    checks++; if ({pif.udin_1, pif.upri_1} !== '0) begin errors++; $display("FAIL reset_payload got udin=%0d upri=%0d exp=0", pif.udin_1, pif.upri_1); end
    checks++; if ({pif.oprt_0, pif.uprt_1} !== '0) begin errors++; $display("FAIL reset_ports got=%b exp=0", {pif.oprt_0, pif.uprt_1}); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty got=%b exp=01", {full, empty}); end
    checks++; if (push_cnt !== 32'd0 || pop_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters got push=%0d pop=%0d exp=0", push_cnt, pop_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_enable;
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 1, 0, '0);
      checks++; if (pif.push_1 !== 1'b0 || push_cnt !== 32'd0) begin errors++; $display("FAIL enable_low_push got push_1=%b cnt=%0d exp=0", pif.push_1, push_cnt); end
    end
    tick(0, 1, 1, 0, '0);
    checks++; if (pif.push_1 !== 1'b1 || pif.udin_1 !== '0) begin errors++; $display("FAIL enable_first_push got push_1=%b udin=%0d exp=1/0", pif.push_1, pif.udin_1); end
    checks++; if (!sb_valid || pif.upri_1 !== sb_exp.prio) begin errors++; $display("FAIL enable_upri got=%0d exp=%0d", pif.upri_1, sb_exp.prio); end
  endtask

  task automatic test_fill(input bit do_reset);
    int n;
    if (do_reset) tick(1, 0, 0, 0, '0);
    n = 0;
    for (int c = 0; c < 135; c++) begin
      tick(0, 1, 1, 0, '0);
      if (pif.push_1) begin
        checks++; if (pif.udin_1 !== BITDATA'(n)) begin errors++; $display("FAIL fill_udin got=%0d exp=%0d", pif.udin_1, n); end
        checks++; if (!sb_valid || pif.upri_1 !== sb_exp.prio) begin errors++; $display("FAIL fill_upri got=%0d exp=%0d", pif.upri_1, sb_exp.prio); end
        n++;
      end
    end
    checks++; if (n !== NUMPIFO) begin errors++; $display("FAIL fill_push_count got=%0d exp=%0d", n, NUMPIFO); end
    checks++; if (full !== 1'b1 || pif.push_1 !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b push_1=%b exp=1/0", full, pif.push_1); end
    checks++; if (occupancy !== 8'd128) begin errors++; $display("FAIL fill_occupancy got=%0d exp=128", occupancy); end
    checks++; if (pif.uprt_1 !== port_sel) begin errors++; $display("FAIL fill_uprt got=%b exp=%b", pif.uprt_1, port_sel); end
  endtask

  task automatic test_drain;
    int n;
    logic [31:0] pc0;
    pc0 = pop_cnt;
    n = 0;
    for (int c = 0; c < 140; c++) begin
      tick(0, 1, 2, 0, '0);
      if (pif.pop_0) n++;
    end
    checks++; if (n !== NUMPIFO) begin errors++; $display("FAIL drain_pop_count got=%0d exp=%0d", n, NUMPIFO); end
    checks++; if (empty !== 1'b1 || pif.pop_0 !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%b pop_0=%b exp=1/0", empty, pif.pop_0); end
    checks++; if (pop_cnt !== pc0 + 32'd128) begin errors++; $display("FAIL drain_pop_cnt got=%0d exp=%0d", pop_cnt, pc0 + 32'd128); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err got=%b exp=0", err); end
  endtask

  task automatic test_exhaust;
    int  n;
    bit  got;
    test_fill(1'b0);
    hold_resp = 1'b1;
    for (int c = 0; c < 4; c++) tick(0, 1, 2, 0, '0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick(0, 1, 1, 0, '0);
      if (pif.push_1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL exhaust_no_push got=%0d pushes exp=0", n); end
    checks++; if (occupancy !== 8'd124) begin errors++; $display("FAIL exhaust_occupancy got=%0d exp=124", occupancy); end
    tick(0, 1, 1, 1, 7'd5);
    checks++; if (pif.push_1 !== 1'b0) begin errors++; $display("FAIL exhaust_same_cycle got push_1=%b exp=0", pif.push_1); end
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      tick(0, 1, 1, 0, '0);
      if (pif.push_1) begin
        got = 1'b1;
        checks++; if (pif.udin_1 !== 7'd5) begin errors++; $display("FAIL exhaust_reuse_id got=%0d exp=5", pif.udin_1); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL exhaust_push_timeout got=none exp=push"); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL exhaust_err got=%b exp=0", err); end
    hold_resp = 1'b0;
  endtask

  task automatic test_bad_id;
    tick(1, 0, 0, 0, '0);
    tick(0, 0, 0, 1, 7'd9);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_id_err got=%b exp=1", err); end
    for (int c = 0; c < 5; c++) begin
      tick(0, 1, 3, 0, '0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_id_sticky got=%b exp=1", err); end
    end
    tick(1, 0, 0, 0, '0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_id_reset got=%b exp=0", err); end
  endtask

  task automatic test_mixed;
    tick(1, 0, 0, 0, '0);
    for (int c = 0; c < 10000; c++) begin
      tick(0, 1, 3, 0, '0);
      checks++; if (pif.push_1 !== e_push || pif.pop_0 !== e_pop) begin errors++; $display("FAIL mixed_strobes cyc=%0d got=%b%b exp=%b%b", cyc, pif.push_1, pif.pop_0, e_push, e_pop); end
      if (pif.push_1) begin
        checks++; if (!sb_valid || pif.udin_1 !== sb_exp.id || pif.upri_1 !== sb_exp.prio) begin errors++; $display("FAIL mixed_payload cyc=%0d got id=%0d pri=%0d exp id=%0d pri=%0d", cyc, pif.udin_1, pif.upri_1, sb_exp.id, sb_exp.prio); end
      end
      checks++; if (occupancy !== 8'(push_cnt - pop_cnt) || occupancy > 8'd128) begin errors++; $display("FAIL mixed_occ_invariant cyc=%0d got=%0d exp=%0d", cyc, occupancy, 8'(push_cnt - pop_cnt)); end
      checks++; if (occupancy !== 8'(m_occ)) begin errors++; $display("FAIL mixed_occ_model cyc=%0d got=%0d exp=%0d", cyc, occupancy, m_occ); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mixed_err cyc=%0d got=%b exp=0", cyc, err); end
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    for (int c = 0; c < 20; c++) tick(0, 1, 3, 0, '0);
    tick(1, 1, 3, 0, '0);
    checks++; if ({pif.push_1, pif.pop_0, pif.udin_1, pif.upri_1, pif.oprt_0, pif.uprt_1} !== '0) begin errors++; $display("FAIL midreset_outputs got push=%b pop=%b udin=%0d upri=%0d exp=0", pif.push_1, pif.pop_0, pif.udin_1, pif.upri_1); end
    checks++; if (occupancy !== '0 || {full, empty} !== 2'b01) begin errors++; $display("FAIL midreset_occ got=%0d fe=%b exp=0/01", occupancy, {full, empty}); end
    checks++; if (push_cnt !== 32'd0 || pop_cnt !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL midreset_counters got push=%0d pop=%0d err=%b exp=0", push_cnt, pop_cnt, err); end
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick(0, 1, 3, 0, '0);
      if (pif.push_1) begin
        got = 1'b1;
        checks++; if (pif.udin_1 !== '0) begin errors++; $display("FAIL midreset_first_id got=%0d exp=0", pif.udin_1); end
        checks++; if (!sb_valid || pif.upri_1 !== sb_exp.prio) begin errors++; $display("FAIL midreset_upri got=%0d exp=%0d", pif.upri_1, sb_exp.prio); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL midreset_push_timeout got=none exp=push"); end
  endtask

  initial begin
    pif.ovld_0  = 1'b0;
    pif.odout_0 = '0;
    test_reset();
    test_enable();
    test_fill(1'b1);
    test_drain();
    test_exhaust();
    test_bad_id();
    test_mixed();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
